// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types, constants and helpers for the TX and RX paths
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD = 1'b1;
  localparam int PRESCALE_W = 6;
  localparam logic [PRESCALE_W-1:0] MIN_PRESCALE = PRESCALE_W'(2);
  function automatic logic [PRESCALE_W-1:0] eff_prescale(input logic [PRESCALE_W-1:0] p);
    return (p < MIN_PRESCALE) ? MIN_PRESCALE : p;
  endfunction
endpackage

// File: rtl/tx_bit_timer.sv
// tx_bit_timer: counts P cycles per bit and pulses bit_done on the last one
module tx_bit_timer
  import uart_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  input  logic [PRESCALE_W-1:0] p,
  output logic                  bit_done
);
  logic [PRESCALE_W-1:0] cnt;
  assign bit_done = run && (cnt == p - 1'b1);
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else cnt <= (!run || bit_done) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: serialises a byte as start, data (LSB first), optional parity, stop
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic                  data_valid,
  input  logic                  par_en,
  input  logic                  par_typ,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tx_out,
  output logic                  busy
);
  localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IW-1:0] LAST = IW'(DATA_WIDTH - 1);
  tx_state_t state;
  logic [DATA_WIDTH-1:0] shreg;
  logic [IW-1:0] idx;
  logic [PRESCALE_W-1:0] p_q;
  logic par_q, par_bit, bit_done;
  tx_bit_timer u_timer (
    .clk(clk),
    .rst(rst),
    .run(busy),
    .p(p_q),
    .bit_done(bit_done)
  );
  // tx_out is loaded with the next state's line level on each transition
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      tx_out <= 1'b1;
      busy <= 1'b0;
      shreg <= '0;
      idx <= '0;
      p_q <= '0;
      par_q <= 1'b0;
      par_bit <= 1'b0;
    end else begin
      case (state)
        IDLE: if (data_valid) begin
          state <= START;
          tx_out <= 1'b0;
          busy <= 1'b1;
          shreg <= p_data;
          idx <= '0;
          p_q <= eff_prescale(prescale);
          par_q <= par_en;
          par_bit <= (^p_data) ^ (par_typ == PAR_ODD);
        end
        START: if (bit_done) begin
          state <= DATA;
          tx_out <= shreg[0];
        end
        DATA: if (bit_done) begin
          shreg <= shreg >> 1;
          idx <= (idx == LAST) ? '0 : idx + 1'b1;
          state <= (idx != LAST) ? DATA : par_q ? PARITY : STOP;
          tx_out <= (idx != LAST) ? shreg[1] : par_q ? par_bit : 1'b1;
        end
        PARITY: if (bit_done) begin
          state <= STOP;
          tx_out <= 1'b1;
        end
        STOP: if (bit_done) begin
          state <= IDLE;
          busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
endmodule
